// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle for the sequential shift controller.
// Master drives requests and consumes results; slave is the controller.
interface shift_seq_ctrl_if #(
    parameter int N = 32
);
    localparam int AW = $clog2(N) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_data;
    logic          req_dir;
    logic [1:0]    req_mode;
    logic [AW-1:0] req_amt;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;

    modport master (
        output req_valid,
        output req_data,
        output req_dir,
        output req_mode,
        output req_amt,
        input  req_ready,
        input  res_valid,
        input  res_data,
        output res_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_dir,
        input  req_mode,
        input  req_amt,
        output req_ready,
        output res_valid,
        output res_data,
        input  res_ready
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// One-bit-per-cycle shift sequencer: accepts a shift request, shifts the
// latched operand one position per enabled cycle, then presents the result.
module shift_seq_ctrl #(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            en,
    shift_seq_ctrl_if.slave bus,
    output logic            busy
);
    localparam int AW = $clog2(N) + 1;
    localparam int LW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  data_q, data_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          rot_q, rot_d;
    logic          ari_q, ari_d;

    logic [N-1:0]  shifted;
    logic [AW-1:0] amt_eff;
    logic          req_rot;
    logic          fill_r;

    assign req_rot = (bus.req_mode == 2'b10);

    // Effective count: rotate wraps modulo N, shifts saturate at N.
    always_comb begin
        amt_eff = bus.req_amt;
        if (req_rot) begin
            amt_eff = {1'b0, bus.req_amt[LW-1:0]};
        end else if (bus.req_amt >= AW'(N)) begin
            amt_eff = AW'(N);
        end
    end

    // Single-position move of the working register.
    always_comb begin
        fill_r  = 1'b0;
        shifted = data_q;
        if (rot_q) begin
            fill_r = data_q[0];
        end else if (ari_q) begin
            fill_r = data_q[N-1];
        end
        if (dir_q) begin
            shifted = {data_q[N-2:0], rot_q & data_q[N-1]};
        end else begin
            shifted = {fill_r, data_q[N-1:1]};
        end
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        ari_d   = ari_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    data_d  = bus.req_data;
                    dir_d   = bus.req_dir;
                    rot_d   = req_rot;
                    ari_d   = (bus.req_mode == 2'b01);
                    cnt_d   = amt_eff;
                    state_d = (amt_eff != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (en) begin
                    data_d = shifted;
                    cnt_d  = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous clear that drops any work in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            ari_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            ari_q   <= ari_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_data  = data_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl at N=8.
// Checks results, latency, hold behaviour, stall and mid-shift clear.
module tb_shift_seq_ctrl;
    logic clk = 1'b0;
    logic clr;
    logic en;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;

    shift_seq_ctrl_if #(.N(8)) bus ();

    shift_seq_ctrl #(.N(8)) dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic dir,
                        input logic [1:0] mode, input logic [3:0] amt);
        int w;
        w = 0;
        while (!bus.req_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        bus.req_data  = d;
        bus.req_dir   = dir;
        bus.req_mode  = mode;
        bus.req_amt   = amt;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic op(input string tag, input logic [7:0] d,
                      input logic dir, input logic [1:0] mode,
                      input logic [3:0] amt, input logic [7:0] exp,
                      input int exp_lat, input int hold, input bit stall);
        int lat;
        send(d, dir, mode, amt);
        lat = 1;
        if (stall) begin
            repeat (2) begin
                @(posedge clk);
                #1;
                lat++;
            end
            en = 1'b0;
            bus.req_valid = 1'b1;
            bus.req_data  = 8'h55;
            check({tag, "_rdy_in_shift"}, 32'(bus.req_ready), 32'd0);
            repeat (3) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check({tag, "_stall_valid"}, 32'(bus.res_valid), 32'd0);
            bus.req_valid = 1'b0;
            en = 1'b1;
        end
        while (!bus.res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(bus.res_data), 32'(exp));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_v"}, 32'(bus.res_valid), 32'd1);
            check({tag, "_hold_d"}, 32'(bus.res_data), 32'(exp));
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        check({tag, "_post_v"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_post_rdy"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        clr           = 1'b1;
        en            = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_dir   = 1'b0;
        bus.req_mode  = 2'b00;
        bus.req_amt   = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_data", 32'(bus.res_data), 32'h00);
        clr = 1'b0;
        @(posedge clk);
        #1;

        op("lsr3", 8'hB4, 1'b0, 2'b00, 4'd3, 8'h16, 4, 3, 1'b0);
        op("asr2", 8'h90, 1'b0, 2'b01, 4'd2, 8'hE4, 3, 0, 1'b0);
        op("asr12", 8'h80, 1'b0, 2'b01, 4'd12, 8'hFF, 9, 0, 1'b0);
        op("lsl9", 8'h81, 1'b1, 2'b00, 4'd9, 8'h00, 9, 0, 1'b0);
        op("rol1", 8'h81, 1'b1, 2'b10, 4'd1, 8'h03, 2, 0, 1'b0);
        op("ror8", 8'h81, 1'b0, 2'b10, 4'd8, 8'h81, 1, 0, 1'b0);
        op("lsr0", 8'h5A, 1'b0, 2'b00, 4'd0, 8'h5A, 1, 0, 1'b0);
        op("rsv2", 8'hF0, 1'b0, 2'b11, 4'd2, 8'h3C, 3, 0, 1'b0);
        op("asl1", 8'hC1, 1'b1, 2'b01, 4'd1, 8'h82, 2, 0, 1'b0);
        op("stall", 8'h01, 1'b1, 2'b00, 4'd5, 8'h20, 9, 0, 1'b1);

        send(8'hFF, 1'b0, 2'b00, 4'd6);
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_valid", 32'(bus.res_valid), 32'd0);
        check("clr_data", 32'(bus.res_data), 32'h00);
        check("clr_ready", 32'(bus.req_ready), 32'd1);
        op("after_clr", 8'h81, 1'b0, 2'b10, 4'd1, 8'hC0, 2, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
